t_using_jk_counter: RTL

- Synchronous modulo-MOD up/down counter whose every state bit is a T flip-flop built from a JK flip-flop (J = K = T[i]).
- Toggle vector per bit: T[i] = Q[i] XOR next[i], computed from the required next count.
- Counterpart of the JK-from-T primitive: here the T behaviour comes from the JK cell, scaled to a loadable counter with terminal-count and wrap outputs.
- Used as the flip-flop-level reference counter for sequencing and timer blocks.

---
 rtl/t_using_jk_counter.sv | 100 ++++++++++
 1 files changed

// File: rtl/t_using_jk_counter.sv
// Modulo-MOD loadable up/down counter whose state bits are JK flip-flops
// wired as T cells (J = K = T), with terminal-count, wrap and load-error flags.
module t_using_jk_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MOD);

  logic [WIDTH-1:0] q_p1;
  logic [WIDTH-1:0] next_p0;
  logic [WIDTH-1:0] t_p0;
  logic [WIDTH-1:0] j_p0;
  logic [WIDTH-1:0] k_p0;
  logic             wrap_p0;
  logic             err_p0;
  logic             wrap_p1;
  logic             err_p1;

  function automatic logic jk_cell(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // Stage p0: choose the next count, then derive per-bit toggle requests
  always_comb begin
    next_p0 = q_p1;
    wrap_p0 = 1'b0;
    err_p0  = 1'b0;
    if (load) begin
      if ({1'b0, din} < MOD_X) begin
        next_p0 = din;
      end else begin
        next_p0 = LAST;
        err_p0  = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        // >= also steers a forced out-of-range state back to zero
        if (q_p1 >= LAST) begin
          next_p0 = '0;
          wrap_p0 = 1'b1;
        end else begin
          next_p0 = q_p1 + ONE;
        end
      end else begin
        if (q_p1 == '0) begin
          next_p0 = LAST;
          wrap_p0 = 1'b1;
        end else begin
          next_p0 = q_p1 - ONE;
        end
      end
    end
  end

  assign t_p0 = q_p1 ^ next_p0;
  assign j_p0 = t_p0;
  assign k_p0 = t_p0;

  // Stage p1: JK cells hold the count; flags register alongside
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_p1    <= '0;
      wrap_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        q_p1[i] <= jk_cell(q_p1[i], j_p0[i], k_p0[i]);
      end
      wrap_p1 <= wrap_p0;
      err_p1  <= err_p0;
    end
  end

  assign Q        = q_p1;
  assign Qb       = ~q_p1;
  assign wrap     = wrap_p1;
  assign load_err = err_p1;
  assign tc       = en & ~load & ((up & (q_p1 == LAST)) | (~up & (q_p1 == '0)));

endmodule
